// File: rtl/fft_pkg.sv
// Shared definitions for the 64-point FFT output path: sizes, bin index
// bit reversal and the reorder buffer's read-side state type.
package fft_pkg;

  localparam int N_POINTS = 64;
  localparam int LOG2N    = 6;
  localparam int DATA_W   = 37;

  // RAM holds two banks of one frame each; the bank bit is the address MSB.
  localparam int RAM_AW = LOG2N + 1;
  localparam int RAM_DW = 2 * DATA_W;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rdState_e;

  // Mirror the bits of a bin index (bit 0 <-> bit LOG2N-1, and so on).
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] rev;
    rev = '0;
    for (int i = 0; i < LOG2N; i++) begin
      rev[i] = idx[LOG2N-1-i];
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample bus between the last butterfly stage, the reorder buffer and the
// downstream consumer. The master side feeds samples in and takes the
// reordered stream out; the slave side is the reorder buffer itself.
interface fft_bitrev_reorder_if;
  import fft_pkg::*;

  logic              iData_valid;
  logic [DATA_W-1:0] iData_Re;
  logic [DATA_W-1:0] iData_Im;

  logic              oData_valid;
  logic [DATA_W-1:0] oData_Re;
  logic [DATA_W-1:0] oData_Im;
  logic [LOG2N-1:0]  oIndex;
  logic              oLast;

  modport master (
    output iData_valid, iData_Re, iData_Im,
    input  oData_valid, oData_Re, oData_Im, oIndex, oLast
  );

  modport slave (
    input  iData_valid, iData_Re, iData_Im,
    output oData_valid, oData_Re, oData_Im, oIndex, oLast
  );

endinterface

// File: rtl/reorder_ram_dp.sv
// Simple dual-port RAM for the reorder buffer: one write port, one read port
// with a registered (synchronous) read. Contents are never reset.
module reorder_ram_dp
  import fft_pkg::*;
(
  input  logic              iClk,
  input  logic              wrEn_i,
  input  logic [RAM_AW-1:0] wrAddr_i,
  input  logic [RAM_DW-1:0] wrData_i,
  input  logic              rdEn_i,
  input  logic [RAM_AW-1:0] rdAddr_i,
  output logic [RAM_DW-1:0] rdData_o
);

  logic [RAM_DW-1:0] mem_q [2*N_POINTS];

  // Store each incoming sample at its bank/bin slot.
  always_ff @(posedge iClk) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  // Registered read: data for an address issued this cycle appears next cycle.
  always_ff @(posedge iClk) begin
    if (rdEn_i) begin
      rdData_o <= mem_q[rdAddr_i];
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorder buffer after the final R2SDF stage: captures bit-reversed frames
// into a ping-pong pair of banks and replays each complete frame in natural
// bin order as a gap-free 64-sample burst.
module fft_bitrev_reorder
  import fft_pkg::*;
(
  input  logic                 iClk,
  input  logic                 Rst,
  fft_bitrev_reorder_if.slave  bus
);

  // Write side state
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic [1:0]       fullSet;

  // Shared bank occupancy flags
  logic [1:0]       full_q, full_d;
  logic [1:0]       fullAvail;
  logic [1:0]       fullClr;

  // Read side state
  rdState_e         state_q, state_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic             rbank_q, rbank_d;

  // RAM ports
  logic              wrEn;
  logic [RAM_AW-1:0] wrAddr;
  logic [RAM_DW-1:0] wrData;
  logic              rdEn;
  logic [RAM_AW-1:0] rdAddr;
  logic [RAM_DW-1:0] rdData;

  // Read pipeline tag, aligned with the RAM's registered read data
  logic              rdValid_q;
  logic [LOG2N-1:0]  rdIndex_q;

  // Output register
  logic              oValid_q;
  logic [DATA_W-1:0] oRe_q;
  logic [DATA_W-1:0] oIm_q;
  logic [LOG2N-1:0]  oIndex_q;
  logic              oLast_q;

  reorder_ram_dp uRam (
    .iClk     (iClk),
    .wrEn_i   (wrEn),
    .wrAddr_i (wrAddr),
    .wrData_i (wrData),
    .rdEn_i   (rdEn),
    .rdAddr_i (rdAddr),
    .rdData_o (rdData)
  );

  // Write side: scatter each valid sample to its bit-reversed slot, and close the bank on the 64th.
  always_comb begin
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    fullSet = '0;
    wrEn    = bus.iData_valid;
    wrAddr  = {wbank_q, bitrev(wcnt_q)};
    wrData  = {bus.iData_Re, bus.iData_Im};
    if (bus.iData_valid) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == LAST_IDX) begin
        fullSet[wbank_q] = 1'b1;
        wbank_d          = ~wbank_q;
      end
    end
  end

  // A bank that completes this cycle counts as ready, so a drain can start
  // (or continue) on the very next cycle without a bubble.
  assign fullAvail = full_q | fullSet;
  assign full_d    = fullAvail & ~fullClr;

  // Read FSM: sweep the ready bank in natural order, chaining straight into the other bank if it is ready too.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    fullClr = '0;
    rdEn    = 1'b0;
    rdAddr  = {rbank_q, rcnt_q};
    case (state_q)
      IDLE: begin
        rcnt_d = '0;
        if (fullAvail[rbank_q]) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        rdEn   = 1'b1;
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == LAST_IDX) begin
          fullClr[rbank_q] = 1'b1;
          rbank_d          = ~rbank_q;
          state_d          = fullAvail[~rbank_q] ? DRAIN : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter, bank pointer, full flag and FSM registers; reset discards any partial or draining frame.
  always_ff @(posedge iClk or posedge Rst) begin
    if (Rst) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
      full_q  <= '0;
      state_q <= IDLE;
      rcnt_q  <= '0;
      rbank_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wbank_q <= wbank_d;
      full_q  <= full_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rbank_q <= rbank_d;
    end
  end

  // Carry the read's valid and bin index alongside the RAM's one-cycle read latency.
  always_ff @(posedge iClk or posedge Rst) begin
    if (Rst) begin
      rdValid_q <= 1'b0;
      rdIndex_q <= '0;
    end else begin
      rdValid_q <= rdEn;
      rdIndex_q <= rcnt_q;
    end
  end

  // Output register: present the sample with its bin index; idle cycles drive zeros.
  always_ff @(posedge iClk or posedge Rst) begin
    if (Rst) begin
      oValid_q <= 1'b0;
      oRe_q    <= '0;
      oIm_q    <= '0;
      oIndex_q <= '0;
      oLast_q  <= 1'b0;
    end else begin
      oValid_q <= rdValid_q;
      oRe_q    <= rdValid_q ? rdData[RAM_DW-1:DATA_W] : '0;
      oIm_q    <= rdValid_q ? rdData[DATA_W-1:0] : '0;
      oIndex_q <= rdValid_q ? rdIndex_q : '0;
      oLast_q  <= rdValid_q && (rdIndex_q == LAST_IDX);
    end
  end

  assign bus.oData_valid = oValid_q;
  assign bus.oData_Re    = oRe_q;
  assign bus.oData_Im    = oIm_q;
  assign bus.oIndex      = oIndex_q;
  assign bus.oLast       = oLast_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for the FFT output reorder buffer.
module tb_fft_bitrev_reorder;

  localparam int W = 37;
  localparam logic [W-1:0] MOST_NEG = 37'h10_0000_0000;
  localparam logic [W-1:0] MOST_POS = 37'h0F_FFFF_FFFF;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [5:0]   idx;
    int           cyc;
  } exp_t;

  typedef struct {
    int           j;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         last;
  } vec_t;

  logic iClk = 1'b0;
  logic Rst  = 1'b0;
  int   cycleCnt = 0;

  int nCompared = 0;
  int nMismatch = 0;
  int outCount  = 0;

  exp_t expQ[$];

  logic [W-1:0] frameRe[64];
  logic [W-1:0] frameIm[64];
  int           benchK = 0;

  logic         capEnable = 1'b0;
  logic [W-1:0] capRe[64];
  logic [W-1:0] capIm[64];
  logic         capLast[64];

  fft_bitrev_reorder_if bus ();

  fft_bitrev_reorder dut (
    .iClk (iClk),
    .Rst  (Rst),
    .bus  (bus)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cycleCnt <= cycleCnt + 1;

  function automatic logic [5:0] brev(input logic [5:0] a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[5-i] = a[i];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Bench model: collect a frame in arrival order, then queue the natural-order outputs.
  task automatic modelPush(input logic [W-1:0] re, input logic [W-1:0] im, input int eCyc);
    exp_t e;
    frameRe[benchK] = re;
    frameIm[benchK] = im;
    benchK++;
    if (benchK == 64) begin
      for (int j = 0; j < 64; j++) begin
        e.re  = frameRe[brev(6'(j))];
        e.im  = frameIm[brev(6'(j))];
        e.idx = 6'(j);
        e.cyc = eCyc + 2 + j;
        expQ.push_back(e);
      end
      benchK = 0;
    end
  endtask

  // Called at posedge+1; drives one sample, then gap idle cycles.
  task automatic applyStimulus(input logic [W-1:0] re, input logic [W-1:0] im, input int gap);
    bus.iData_valid = 1'b1;
    bus.iData_Re    = re;
    bus.iData_Im    = im;
    @(posedge iClk);
    #1;
    modelPush(re, im, cycleCnt);
    bus.iData_valid = 1'b0;
    repeat (gap) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic resetDut();
    Rst = 1'b1;
    bus.iData_valid = 1'b0;
    #1;
    checkOutput("rst_valid", 64'(bus.oData_valid), 64'd0);
    checkOutput("rst_re",    64'(bus.oData_Re),    64'd0);
    checkOutput("rst_im",    64'(bus.oData_Im),    64'd0);
    checkOutput("rst_index", 64'(bus.oIndex),      64'd0);
    checkOutput("rst_last",  64'(bus.oLast),       64'd0);
    expQ.delete();
    benchK = 0;
    repeat (2) @(posedge iClk);
    #1;
    Rst = 1'b0;
    @(posedge iClk);
    #1;
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && expQ.size() > 0; i++) @(negedge iClk);
    checkOutput("drain_pending", 64'(expQ.size()), 64'd0);
    repeat (4) @(posedge iClk);
    #1;
  endtask

  task automatic sendFrame(input int base, input int imBase, input int gap);
    for (int k = 0; k < 64; k++) begin
      applyStimulus(W'(base + k), W'(imBase) - W'(k), gap);
    end
  endtask

  // Monitor: every valid output must match the head of the scoreboard, on its expected cycle.
  always @(negedge iClk) begin
    exp_t e;
    if (Rst == 1'b0 && bus.oData_valid === 1'b1) begin
      outCount++;
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatch++;
        $display("[TB] FAIL unexpected_output: got idx %0d re %0h, expected no output (t=%0t)",
                 bus.oIndex, bus.oData_Re, $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_index", 64'(bus.oIndex), 64'(e.idx));
        checkOutput("out_re",    64'(bus.oData_Re), 64'(e.re));
        checkOutput("out_im",    64'(bus.oData_Im), 64'(e.im));
        checkOutput("out_last",  64'(bus.oLast), 64'(e.idx == 6'd63));
        checkOutput("out_cycle", 64'(cycleCnt), 64'(e.cyc));
      end
      if (capEnable) begin
        capRe[bus.oIndex]   = bus.oData_Re;
        capIm[bus.oIndex]   = bus.oData_Im;
        capLast[bus.oIndex] = bus.oLast;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   startCnt;
    logic found;

    vecs[0] = '{j: 0,  re: 37'd0,  im: 37'd0,          last: 1'b0};
    vecs[1] = '{j: 1,  re: 37'd32, im: 37'd0 - 37'd32, last: 1'b0};
    vecs[2] = '{j: 3,  re: 37'd48, im: 37'd0 - 37'd48, last: 1'b0};
    vecs[3] = '{j: 6,  re: 37'd24, im: 37'd0 - 37'd24, last: 1'b0};
    vecs[4] = '{j: 62, re: 37'd31, im: 37'd0 - 37'd31, last: 1'b0};
    vecs[5] = '{j: 63, re: 37'd63, im: 37'd0 - 37'd63, last: 1'b1};

    bus.iData_valid = 1'b0;
    bus.iData_Re    = '0;
    bus.iData_Im    = '0;
    #2;
    $display("[TB] reset state");
    resetDut();

    $display("[TB] single frame, bit reversal");
    capEnable = 1'b1;
    startCnt  = outCount;
    sendFrame(0, 0, 0);
    waitDrain(200);
    capEnable = 1'b0;
    checkOutput("single_burst_len", 64'(outCount - startCnt), 64'd64);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("tbl_re_j%0d", vecs[i].j),   64'(capRe[vecs[i].j]),   64'(vecs[i].re));
      checkOutput($sformatf("tbl_im_j%0d", vecs[i].j),   64'(capIm[vecs[i].j]),   64'(vecs[i].im));
      checkOutput($sformatf("tbl_last_j%0d", vecs[i].j), 64'(capLast[vecs[i].j]), 64'(vecs[i].last));
    end

    $display("[TB] gapped input");
    startCnt = outCount;
    sendFrame(0, 0, 2);
    waitDrain(200);
    checkOutput("gapped_burst_len", 64'(outCount - startCnt), 64'd64);

    $display("[TB] continuous streaming, 4 frames");
    startCnt = outCount;
    for (int f = 0; f < 4; f++) begin
      sendFrame(100 * f, 1000 * f, 0);
    end
    waitDrain(400);
    checkOutput("stream_burst_len", 64'(outCount - startCnt), 64'd256);

    $display("[TB] sign and width extremes");
    for (int k = 0; k < 64; k++) begin
      if (k % 2 == 0) applyStimulus(MOST_NEG, MOST_POS, 0);
      else            applyStimulus(MOST_POS, MOST_NEG, 0);
    end
    waitDrain(200);

    $display("[TB] reset mid-drain");
    sendFrame(200, 2000, 0);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge iClk);
      if (bus.oData_valid === 1'b1 && bus.oIndex === 6'd20) found = 1'b1;
    end
    checkOutput("reached_j20", 64'(found), 64'd1);
    #1;
    resetDut();
    startCnt = outCount;
    sendFrame(300, 3000, 0);
    waitDrain(200);
    checkOutput("post_drain_rst_len", 64'(outCount - startCnt), 64'd64);

    $display("[TB] reset mid-fill");
    for (int k = 0; k < 30; k++) applyStimulus(W'(400 + k), W'(4000 + k), 0);
    resetDut();
    startCnt = outCount;
    sendFrame(500, 5000, 1);
    waitDrain(200);
    checkOutput("post_fill_rst_len", 64'(outCount - startCnt), 64'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
